// File: rtl/pkt_wrr_sched_avlstrm.sv
// pkt_wrr_sched_avlstrm: packet-atomic weighted round-robin merge of NUM_IN Avalon-ST inputs onto one egress stream.
// Each input may start cfg_weight[i] whole packets per round; beats of different packets never interleave.
module pkt_wrr_sched_avlstrm #(
  parameter int NUM_IN   = 5,
  parameter int DWIDTH   = 512,
  parameter int EWIDTH   = 6,
  parameter int WEIGHT_W = 4
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic [NUM_IN-1:0]          in_valid,
  input  logic [NUM_IN*DWIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]          in_sop,
  input  logic [NUM_IN-1:0]          in_eop,
  input  logic [NUM_IN*EWIDTH-1:0]   in_empty,
  output logic [NUM_IN-1:0]          in_ready,
  output logic                       out_valid,
  output logic [DWIDTH-1:0]          out_data,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [EWIDTH-1:0]          out_empty,
  input  logic                       out_ready,
  input  logic                       out_almostfull,
  input  logic [NUM_IN*WEIGHT_W-1:0] cfg_weight,
  output logic [2:0]                 grant_idx,
  output logic [31:0]                pkt_cnt
);
  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;
  state_t                          state_q, state_d;
  logic [NUM_IN-1:0][WEIGHT_W-1:0] credit_q, credit_d;
  logic [2:0]                      rr_q, rr_d, grant_q, grant_d, pick, cand;
  logic [3:0]                      sum;
  logic                            found, rdy, acc;
  logic [NUM_IN-1:0]               elig, wnz;
  logic                            out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic [DWIDTH-1:0]               out_data_q, out_data_d, sel_data;
  logic [EWIDTH-1:0]               out_empty_q, out_empty_d, sel_empty;
  logic [31:0]                     pkt_cnt_q, pkt_cnt_d;

  assign rdy       = !out_valid_q || out_ready;
  assign acc       = state_q == XFER && rdy && in_valid[grant_q];
  assign in_ready  = state_q == XFER ? NUM_IN'(rdy) << grant_q : '0;
  assign sel_data  = in_data[int'(grant_q)*DWIDTH +: DWIDTH];
  assign sel_empty = in_empty[int'(grant_q)*EWIDTH +: EWIDTH];

  always_comb begin
    elig = '0;
    wnz  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      elig[i] = in_valid[i] && in_sop[i] && |credit_q[i];
      wnz[i]  = |cfg_weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  // rotating priority: scanning from farthest to nearest leaves the first eligible input at/after rr_q
  always_comb begin
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      sum  = 4'(rr_q) + 4'(k);
      cand = 3'(sum >= 4'(NUM_IN) ? sum - 4'(NUM_IN) : sum);
      if (elig[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        credit_d = cfg_weight;
        state_d  = ARB;
      end
      ARB: begin
        if (found && !out_almostfull) begin
          grant_d        = pick;
          credit_d[pick] = credit_q[pick] - WEIGHT_W'(1);
          rr_d           = pick == 3'(NUM_IN - 1) ? 3'd0 : pick + 3'd1;
          state_d        = XFER;
        end else if (!found && |(in_valid & in_sop & wnz)) begin
          credit_d = cfg_weight;
        end
      end
      XFER:    state_d = acc && in_eop[grant_q] ? ARB : XFER;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = rdy ? acc : out_valid_q;
    out_data_d  = acc ? sel_data : out_data_q;
    out_sop_d   = acc ? in_sop[grant_q] : out_sop_q;
    out_eop_d   = acc ? in_eop[grant_q] : out_eop_q;
    out_empty_d = acc ? sel_empty : out_empty_q;
    pkt_cnt_d   = pkt_cnt_q + 32'(out_valid_q && out_ready && out_eop_q);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      rr_q        <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_empty_q <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_empty_q <= out_empty_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_empty = out_empty_q;
  assign grant_idx = grant_q;
  assign pkt_cnt   = pkt_cnt_q;
endmodule
